// File: rtl/scarv_cop_aes_arb_pkg.sv
// Shared definitions for the coprocessor AES unit arbiter.
//   - AES sub/mix subclass encodings understood by the shared unit
//   - arbiter FSM state encoding
//   - sclass_legal(): true for subclasses the AES unit can execute
package scarv_cop_aes_arb_pkg;

  localparam logic [4:0] AESSUB_ENC    = 5'h00;
  localparam logic [4:0] AESSUB_ENCROT = 5'h01;
  localparam logic [4:0] AESSUB_DEC    = 5'h02;
  localparam logic [4:0] AESSUB_DECROT = 5'h03;
  localparam logic [4:0] AESMIX_ENC    = 5'h04;
  localparam logic [4:0] AESMIX_DEC    = 5'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  function automatic logic sclass_legal(input logic [4:0] sc);
    logic ok;
    case (sc)
      AESSUB_ENC, AESSUB_ENCROT, AESSUB_DEC, AESSUB_DECROT,
      AESMIX_ENC, AESMIX_DEC: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/scarv_cop_aes_arb_pick.sv
// Combinational requester selection for the AES unit arbiter.
// The search starts at start_i and wraps modulo NREQ; tying start_i to 0
// gives fixed priority with the lowest index winning.
// Ports:
//   valid_i  [NREQ]  request valids
//   start_i  [2]     first index to consider
//   grant_o  [NREQ]  one-hot grant (zero when nothing is valid)
//   idx_o    [2]     index of the granted requester
//   any_o    [1]     some requester was granted
module scarv_cop_aes_arb_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [1:0]      start_i,
  output logic [NREQ-1:0] grant_o,
  output logic [1:0]      idx_o,
  output logic            any_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = 2'd0;
    any_o   = 1'b0;
    // Outer loop walks the search order; inner loop keeps every bit
    // select constant so the hardware is a plain priority mux.
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_o && valid_i[i] && (((int'(start_i) + k) % NREQ) == i)) begin
          grant_o[i] = 1'b1;
          idx_o      = 2'(i);
          any_o      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scarv_cop_aes_arb.sv
// Shares the coprocessor AES sub/mix unit between NREQ requesters.
// A request is arbitrated and captured in IDLE, the unit's valid and
// operands are held stable through BUSY, and the tagged result is offered
// on a single response channel in RESP.
// Build option: SCARV_COP_AES_ARB_RR_EN selects round-robin arbitration;
// without it the lowest requester index wins and no pointer is built.
// Ports:
//   g_clk, g_reset            clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (ready one-hot or 0)
//   req_rs1/rs2/sclass        per-requester operands, slice i = requester i
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_data/rsp_err   response requester, result, error flag
//   aes_ivalid/rs1/rs2/sclass drive the shared AES unit
//   aes_idone/aes_wdata       AES unit completion and result
//
// state | meaning
// IDLE  | waiting for a request; req_ready shows the winner
// BUSY  | AES unit running on captured operands; timeout counter active
// RESP  | response held on rsp_* until rsp_ready
module scarv_cop_aes_arb
  import scarv_cop_aes_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 7
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_rs1,
  input  logic [32*NREQ-1:0] req_rs2,
  input  logic [5*NREQ-1:0] req_sclass,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              aes_ivalid,
  output logic [31:0]       aes_rs1,
  output logic [31:0]       aes_rs2,
  output logic [4:0]        aes_sclass,
  input  logic              aes_idone,
  input  logic [31:0]       aes_wdata
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    id_q, id_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic [4:0]    sc_q, sc_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] pick_grant;
  logic [1:0]      pick_idx;
  logic            pick_any;
  logic [1:0]      pick_start;
  logic [31:0]     win_rs1, win_rs2;
  logic [4:0]      win_sc;

  scarv_cop_aes_arb_pick #(.NREQ(NREQ)) u_pick (
    .valid_i (req_valid),
    .start_i (pick_start),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef SCARV_COP_AES_ARB_RR_EN
  // Pointer holds the next search start, i.e. last grant + 1.
  // Updated on every accept, including illegal-subclass accepts.
  logic [1:0] ptr_q, ptr_d;

  assign pick_start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && pick_any)
      ptr_d = (pick_idx == 2'(NREQ - 1)) ? 2'd0 : pick_idx + 2'd1;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) ptr_q <= 2'd0;
    else         ptr_q <= ptr_d;
  end
`else
  assign pick_start = 2'd0;
`endif

  // One-hot grant makes an OR-style mux sufficient.
  always_comb begin
    win_rs1 = '0;
    win_rs2 = '0;
    win_sc  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        win_rs1 = req_rs1[32*i +: 32];
        win_rs2 = req_rs2[32*i +: 32];
        win_sc  = req_sclass[5*i +: 5];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    sc_d      = sc_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = pick_grant;
        if (pick_any) begin
          id_d  = pick_idx;
          cnt_d = '0;
          if (sclass_legal(win_sc)) begin
            // Operand registers only move for work the unit will see,
            // so the unit's inputs stay quiet on rejected requests.
            rs1_d   = win_rs1;
            rs2_d   = win_rs2;
            sc_d    = win_sc;
            state_d = ST_BUSY;
          end else begin
            data_d  = 32'h0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (aes_idone) begin
          data_d  = aes_wdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = 32'h0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      id_q    <= 2'd0;
      rs1_q   <= 32'h0;
      rs2_q   <= 32'h0;
      sc_q    <= 5'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      sc_q    <= sc_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign aes_ivalid = (state_q == ST_BUSY);
  assign aes_rs1    = rs1_q;
  assign aes_rs2    = rs2_q;
  assign aes_sclass = sc_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_scarv_cop_aes_arb.sv
// Self-checking bench for scarv_cop_aes_arb with a behavioural AES unit
// (real S-box, programmable completion latency, latency 100 = never done).
module tb_scarv_cop_aes_arb;
  import scarv_cop_aes_arb_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 7;

  logic                 g_clk = 1'b0;
  logic                 g_reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_rs1;
  logic [32*NREQ-1:0]   req_rs2;
  logic [5*NREQ-1:0]    req_sclass;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [31:0]          rsp_data;
  logic                 rsp_err;
  logic                 aes_ivalid;
  logic [31:0]          aes_rs1;
  logic [31:0]          aes_rs2;
  logic [4:0]           aes_sclass;
  logic                 aes_idone;
  logic [31:0]          aes_wdata;

  always #5 g_clk = ~g_clk;

  scarv_cop_aes_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_sclass (req_sclass),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .aes_ivalid (aes_ivalid),
    .aes_rs1    (aes_rs1),
    .aes_rs2    (aes_rs2),
    .aes_sclass (aes_sclass),
    .aes_idone  (aes_idone),
    .aes_wdata  (aes_wdata)
  );

  // ---------------- behavioural AES unit ----------------
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];
  int         stub_lat = 4;
  int         ph;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sc);
    logic [31:0] s, iv;
    for (int k = 0; k < 4; k++) begin
      s[8*k +: 8]  = sbox_t[a[8*k +: 8]];
      iv[8*k +: 8] = isbox_t[a[8*k +: 8]];
    end
    case (sc)
      AESSUB_ENC:    return s;
      AESSUB_ENCROT: return {s[23:0], s[31:24]};
      AESSUB_DEC:    return iv;
      AESSUB_DECROT: return {iv[23:0], iv[31:24]};
      AESMIX_ENC:    return a ^ {b[15:0], b[31:16]};
      AESMIX_DEC:    return a ^ ~b;
      default:       return 32'hdead_beef;
    endcase
  endfunction

  always @(posedge g_clk) begin
    if (g_reset || !aes_ivalid) ph <= 0;
    else                        ph <= ph + 1;
  end

  assign aes_idone = aes_ivalid && (ph == stub_lat - 1);
  assign aes_wdata = unit_fn(aes_rs1, aes_rs2, aes_sclass);

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus state and model ----------------
  logic [NREQ-1:0] v_valid;
  logic [31:0]     t_rs1 [NREQ];
  logic [31:0]     t_rs2 [NREQ];
  logic [4:0]      t_sc  [NREQ];
  logic [4:0]      legal_sc [6] = '{AESSUB_ENC, AESSUB_ENCROT, AESSUB_DEC,
                                    AESSUB_DECROT, AESMIX_ENC, AESMIX_DEC};
  int              rr_start = 0;

  task automatic nxt();
    @(negedge g_clk);
    #1;
  endtask

  task automatic drive();
    req_valid = v_valid;
    for (int i = 0; i < NREQ; i++) begin
      req_rs1[32*i +: 32]  = t_rs1[i];
      req_rs2[32*i +: 32]  = t_rs2[i];
      req_sclass[5*i +: 5] = t_sc[i];
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] m, input int start);
`ifdef SCARV_COP_AES_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) if (m[(start + k) % NREQ]) return (start + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++) if (m[k]) return k;
`endif
    return -1;
  endfunction

  function automatic bit model_legal(input logic [4:0] sc);
    for (int i = 0; i < 6; i++) if (legal_sc[i] == sc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk_zero(input string tag);
    chk(tag, {22'h0, req_ready, rsp_valid, rsp_err, rsp_id, aes_ivalid, aes_sclass}, 32'h0);
    chk(tag, rsp_data | aes_rs1 | aes_rs2, 32'h0);
  endtask

  // One transaction from IDLE: drive, check grant, follow BUSY, check the
  // response, hold it for 'hold' cycles, then hand it off.
  task automatic run_op(input int lat, input int hold, input bit keep,
                        output int w, output logic [31:0] got_data);
    int          exp_busy, k_rsp, n_iv;
    bit          legal, exp_err, ops_ok, hold_ok;
    logic [31:0] exp_data, c_rs1, c_rs2;
    logic [4:0]  c_sc;
    got_data = 32'hx;
    drive();
    #1;
    w = model_pick(v_valid, rr_start);
    if (w < 0) begin
      chk("ready_none", {30'h0, req_ready}, 32'h0);
      nxt();
      return;
    end
    chk("req_ready", {30'h0, req_ready}, 32'(1 << w));
    c_rs1    = t_rs1[w];
    c_rs2    = t_rs2[w];
    c_sc     = t_sc[w];
    legal    = model_legal(c_sc);
    exp_busy = !legal ? 0 : ((lat <= TIMEOUT) ? lat : TIMEOUT);
    exp_err  = !legal || (lat > TIMEOUT);
    exp_data = exp_err ? 32'h0 : unit_fn(c_rs1, c_rs2, c_sc);
    stub_lat = lat;
`ifdef SCARV_COP_AES_ARB_RR_EN
    rr_start = (w + 1) % NREQ;
`endif
    nxt();
    if (!keep) begin
      v_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
        t_rs1[i] = $urandom;
        t_rs2[i] = $urandom;
        t_sc[i]  = 5'($urandom);
      end
    end
    drive();
    n_iv = 0; k_rsp = -1; ops_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        k_rsp = k;
        break;
      end
      if (aes_ivalid) begin
        n_iv++;
        if (aes_rs1 !== c_rs1 || aes_rs2 !== c_rs2 || aes_sclass !== c_sc) ops_ok = 1'b0;
      end
      if (req_ready !== '0) ops_ok = 1'b0;
      nxt();
    end
    chk("rsp_latency", k_rsp, exp_busy + 1);
    chk("ivalid_cycles", n_iv, exp_busy);
    chk("busy_ops_stable", {31'h0, ops_ok}, 32'h1);
    if (k_rsp < 0) return;
    got_data = rsp_data;
    chk("rsp_id", {30'h0, rsp_id}, w);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      nxt();
      if (!rsp_valid || rsp_id !== 2'(w) || rsp_data !== exp_data || rsp_err !== exp_err ||
          req_ready !== '0 || aes_ivalid !== 1'b0) hold_ok = 1'b0;
    end
    if (hold > 0) chk("rsp_hold_stable", {31'h0, hold_ok}, 32'h1);
    rsp_ready = 1'b1;
    #1;
    chk("no_ready_in_resp", {30'h0, req_ready}, 32'h0);
    nxt();
    rsp_ready = 1'b0;
    chk("rsp_released", {31'h0, rsp_valid}, 32'h0);
  endtask

  task automatic pulse_reset();
    g_reset = 1'b1;
    nxt();
    g_reset  = 1'b0;
    rr_start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          ids [4];
    int          exp_seq [4];
    logic [31:0] d;
    bit          quiet;

    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv, b, s;
      inv = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox_t[v]  = s;
      isbox_t[s] = 8'(v);
    end

    g_reset   = 1'b1;
    rsp_ready = 1'b0;
    v_valid   = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_rs1[i] = 32'h0; t_rs2[i] = 32'h0; t_sc[i] = 5'h0;
    end
    drive();
    nxt(); nxt(); nxt();
    chk_zero("reset_state");
    g_reset = 1'b0;

    // requester 0, SubBytes encrypt of zero
    v_valid = 2'b01; t_sc[0] = AESSUB_ENC; t_rs1[0] = 32'h0; t_rs2[0] = 32'h0;
    run_op(4, 0, 1'b0, w, d);
    chk("sub_enc_zero", d, 32'h6363_6363);

    // requester 1, inverse SubBytes back to zero
    v_valid = 2'b10; t_sc[1] = AESSUB_DEC; t_rs1[1] = 32'h6363_6363; t_rs2[1] = 32'h6363_6363;
    run_op(4, 0, 1'b0, w, d);
    chk("sub_dec_63", d, 32'h0);
    chk("sub_dec_id", w, 1);

    // both requesters valid for four back-to-back operations
`ifdef SCARV_COP_AES_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    v_valid = 2'b11;
    t_sc[0] = AESSUB_ENC;  t_rs1[0] = $urandom; t_rs2[0] = $urandom;
    t_sc[1] = AESMIX_DEC;  t_rs1[1] = $urandom; t_rs2[1] = $urandom;
    for (int k = 0; k < 4; k++) begin
      run_op(4, 0, 1'b1, w, d);
      ids[k] = w;
    end
    for (int k = 0; k < 4; k++) chk("arb_order", ids[k], exp_seq[k]);

    // illegal subclass never reaches the unit
    v_valid = 2'b01; t_sc[0] = 5'h1f; t_rs1[0] = $urandom;
    run_op(4, 0, 1'b0, w, d);

    // response back-pressure with both requesters still asking
    v_valid = 2'b11; t_sc[0] = AESSUB_DECROT; t_sc[1] = AESSUB_ENCROT;
    run_op(4, 10, 1'b1, w, d);

    // unit never completes -> timeout, then reset and resume
    v_valid = 2'b01; t_sc[0] = AESMIX_ENC; t_rs1[0] = $urandom; t_rs2[0] = $urandom;
    run_op(100, 0, 1'b0, w, d);
    pulse_reset();
    v_valid = 2'b10; t_sc[1] = AESSUB_ENC; t_rs1[1] = 32'h0000_0001; t_rs2[1] = 32'h0;
    run_op(4, 0, 1'b0, w, d);
    chk("after_timeout_data", d, 32'h6363_637c);

    // reset in the middle of BUSY abandons the operation
    v_valid = 2'b01; t_sc[0] = AESSUB_ENC; t_rs1[0] = $urandom;
    drive();
    nxt();
    v_valid = '0;
    drive();
    nxt();
    g_reset = 1'b1;
    nxt();
    chk_zero("reset_mid_busy");
    g_reset  = 1'b0;
    rr_start = 0;
    quiet    = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid || aes_ivalid) quiet = 1'b0;
      nxt();
    end
    chk("no_rsp_after_reset", {31'h0, quiet}, 32'h1);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      v_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        t_rs1[i] = $urandom;
        t_rs2[i] = $urandom;
        if ($urandom_range(0, 3) != 0) t_sc[i] = legal_sc[$urandom_range(0, 5)];
        else                           t_sc[i] = 5'($urandom);
      end
      run_op($urandom_range(1, 9), $urandom_range(0, 3), 1'b0, w, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
